// File: rtl/rs_custom_pkg.sv
// Shared widths, entry payload layout and the speculation-tag match helper
// for the custom-unit reservation station.
package rs_custom_pkg;

  localparam int DATA_LEN        = 32;
  localparam int RRF_SEL         = 6;
  localparam int SPECTAG_LEN     = 5;
  localparam int SRC_A_SEL_WIDTH = 2;
  localparam int SRC_B_SEL_WIDTH = 2;
  localparam int FUNCT7_WIDTH    = 7;
  localparam int FUNCT3_WIDTH    = 3;
  localparam int PASS_LEN        = 25;

  typedef struct packed {
    logic [DATA_LEN-1:0]        imm;
    logic [RRF_SEL-1:0]         rrftag;
    logic                       dstval;
    logic [SRC_A_SEL_WIDTH-1:0] src_a;
    logic [SRC_B_SEL_WIDTH-1:0] src_b;
    logic [FUNCT7_WIDTH-1:0]    funct7;
    logic [FUNCT3_WIDTH-1:0]    funct3;
    logic [PASS_LEN-1:0]        passbits;
    logic [SPECTAG_LEN-1:0]     spectag;
    logic                       specbit;
  } rs_payload_t;

  function automatic logic spec_hit(input logic specbit,
                                    input logic [SPECTAG_LEN-1:0] tag,
                                    input logic [SPECTAG_LEN-1:0] fix);
    return specbit && (|(tag & fix));
  endfunction

endpackage

// File: rtl/rs_custom_select.sv
// Picks one ready entry: lowest index, or oldest-then-lowest-index when
// RS_CUSTOM_AGE_SELECT_EN is defined.
module rs_custom_select #(
  parameter int ENT_NUM = 4,
  parameter int ENT_SEL = 2
) (
  input  logic [ENT_NUM-1:0]              ready,
`ifdef RS_CUSTOM_AGE_SELECT_EN
  input  logic [ENT_NUM-1:0][ENT_SEL-1:0] ages,
`endif
  output logic [ENT_NUM-1:0]              grant,
  output logic [ENT_SEL-1:0]              grant_idx,
  output logic                            any_ready
);

  always_comb begin
    grant_idx = '0;
    any_ready = 1'b0;
`ifdef RS_CUSTOM_AGE_SELECT_EN
    // strict compare keeps the lower index on equal age
    for (int i = 0; i < ENT_NUM; i++)
      if (ready[i] && (!any_ready || ages[i] > ages[grant_idx])) begin
        any_ready = 1'b1;
        grant_idx = ENT_SEL'(i);
      end
`else
    for (int i = ENT_NUM-1; i >= 0; i--)
      if (ready[i]) begin
        any_ready = 1'b1;
        grant_idx = ENT_SEL'(i);
      end
`endif
    grant = '0;
    if (any_ready) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rs_custom.sv
// Reservation station for the custom execution unit: dispatch, tag wakeup,
// select/issue, branch kill/promote. Optional age select: RS_CUSTOM_AGE_SELECT_EN.
module rs_custom
  import rs_custom_pkg::*;
#(
  parameter int ENT_NUM = 4,
  parameter int NUM_WB  = 4,
  parameter int ENT_SEL = $clog2(ENT_NUM)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       dp_we,
  input  logic [DATA_LEN-1:0]        dp_src1,
  input  logic [DATA_LEN-1:0]        dp_src2,
  input  logic                       dp_rdy1,
  input  logic                       dp_rdy2,
  input  logic [DATA_LEN-1:0]        dp_imm,
  input  logic [RRF_SEL-1:0]         dp_rrftag,
  input  logic                       dp_dstval,
  input  logic [SRC_A_SEL_WIDTH-1:0] dp_src_a,
  input  logic [SRC_B_SEL_WIDTH-1:0] dp_src_b,
  input  logic [FUNCT7_WIDTH-1:0]    dp_funct7,
  input  logic [FUNCT3_WIDTH-1:0]    dp_funct3,
  input  logic [PASS_LEN-1:0]        dp_passbits,
  input  logic [SPECTAG_LEN-1:0]     dp_spectag,
  input  logic                       dp_specbit,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*RRF_SEL-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_LEN-1:0] wb_data,
  input  logic                       ex_ready,
  input  logic                       prmiss,
  input  logic                       prsuccess,
  input  logic [SPECTAG_LEN-1:0]     spectagfix,
  output logic                       issue,
  output logic [DATA_LEN-1:0]        ex_src1,
  output logic [DATA_LEN-1:0]        ex_src2,
  output logic [DATA_LEN-1:0]        ex_imm,
  output logic [RRF_SEL-1:0]         ex_rrftag,
  output logic                       ex_dstval,
  output logic [SRC_A_SEL_WIDTH-1:0] ex_src_a,
  output logic [SRC_B_SEL_WIDTH-1:0] ex_src_b,
  output logic [FUNCT7_WIDTH-1:0]    ex_funct7,
  output logic [FUNCT3_WIDTH-1:0]    ex_funct3,
  output logic [PASS_LEN-1:0]        ex_passbits,
  output logic [SPECTAG_LEN-1:0]     ex_spectag,
  output logic                       ex_specbit,
  output logic                       full,
  output logic [ENT_SEL:0]           count
);

  rs_payload_t                       pay [ENT_NUM];
  rs_payload_t                       dp_pay;
  logic [ENT_NUM-1:0]                valid, valid_nxt, rdy1, rdy2, ready, grant;
  logic [ENT_NUM-1:0][DATA_LEN-1:0]  src1, src2, wk1_data, wk2_data;
  logic [ENT_NUM-1:0]                wk1_hit, wk2_hit;
  logic                              dp1_hit, dp2_hit;
  logic [DATA_LEN-1:0]               dp1_data, dp2_data;
  logic [ENT_SEL-1:0]                sel_idx, free_idx;
  logic                              any_ready, sel_kill, dp_kill, dp_write, succ;
  logic [ENT_SEL:0]                  cnt_nxt;

  // lowest-index matching bus wins
  function automatic logic [DATA_LEN:0] wb_match(input logic [RRF_SEL-1:0]         tag,
                                                 input logic [NUM_WB-1:0]          vld,
                                                 input logic [NUM_WB*RRF_SEL-1:0]  tags,
                                                 input logic [NUM_WB*DATA_LEN-1:0] data);
    logic [DATA_LEN:0] r;
    r = '0;
    for (int b = NUM_WB-1; b >= 0; b--)
      if (vld[b] && tags[b*RRF_SEL +: RRF_SEL] == tag)
        r = {1'b1, data[b*DATA_LEN +: DATA_LEN]};
    return r;
  endfunction

  always_comb begin
    {dp1_hit, dp1_data} = wb_match(dp_src1[RRF_SEL-1:0], wb_valid, wb_tag, wb_data);
    {dp2_hit, dp2_data} = wb_match(dp_src2[RRF_SEL-1:0], wb_valid, wb_tag, wb_data);
    for (int i = 0; i < ENT_NUM; i++) begin
      {wk1_hit[i], wk1_data[i]} = wb_match(src1[i][RRF_SEL-1:0], wb_valid, wb_tag, wb_data);
      {wk2_hit[i], wk2_data[i]} = wb_match(src2[i][RRF_SEL-1:0], wb_valid, wb_tag, wb_data);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = ENT_NUM-1; i >= 0; i--)
      if (!valid[i]) free_idx = ENT_SEL'(i);
  end

  assign ready    = valid & rdy1 & rdy2;
  assign succ     = prsuccess && !prmiss;
  assign sel_kill = prmiss && spec_hit(pay[sel_idx].specbit, pay[sel_idx].spectag, spectagfix);
  assign issue    = ex_ready && any_ready && !sel_kill;
  assign dp_kill  = prmiss && spec_hit(dp_specbit, dp_spectag, spectagfix);
  // full is the registered pre-edge view, so a same-cycle free does not admit a dispatch
  assign dp_write = dp_we && !full && !dp_kill;

  always_comb begin
    dp_pay          = '0;
    dp_pay.imm      = dp_imm;
    dp_pay.rrftag   = dp_rrftag;
    dp_pay.dstval   = dp_dstval;
    dp_pay.src_a    = dp_src_a;
    dp_pay.src_b    = dp_src_b;
    dp_pay.funct7   = dp_funct7;
    dp_pay.funct3   = dp_funct3;
    dp_pay.passbits = dp_passbits;
    dp_pay.spectag  = dp_spectag;
    dp_pay.specbit  = dp_specbit && !(succ && (|(dp_spectag & spectagfix)));
  end

  always_comb begin
    valid_nxt = valid;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (prmiss && spec_hit(pay[i].specbit, pay[i].spectag, spectagfix)) valid_nxt[i] = 1'b0;
      if (issue && grant[i]) valid_nxt[i] = 1'b0;
    end
    if (dp_write) valid_nxt[free_idx] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < ENT_NUM; i++)
      cnt_nxt = cnt_nxt + {{ENT_SEL{1'b0}}, valid_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      valid <= valid_nxt;
      count <= cnt_nxt;
      full  <= (cnt_nxt == (ENT_SEL+1)'(ENT_NUM));
    end
  end

  // payload and operand state are qualified by valid, so they carry no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENT_NUM; i++) begin
      if (dp_write && free_idx == ENT_SEL'(i)) begin
        pay[i]  <= dp_pay;
        rdy1[i] <= dp_rdy1 | dp1_hit;
        rdy2[i] <= dp_rdy2 | dp2_hit;
        src1[i] <= (!dp_rdy1 && dp1_hit) ? dp1_data : dp_src1;
        src2[i] <= (!dp_rdy2 && dp2_hit) ? dp2_data : dp_src2;
      end else begin
        if (!rdy1[i] && wk1_hit[i]) begin
          rdy1[i] <= 1'b1;
          src1[i] <= wk1_data[i];
        end
        if (!rdy2[i] && wk2_hit[i]) begin
          rdy2[i] <= 1'b1;
          src2[i] <= wk2_data[i];
        end
        if (succ && spec_hit(pay[i].specbit, pay[i].spectag, spectagfix))
          pay[i].specbit <= 1'b0;
      end
    end
  end

`ifdef RS_CUSTOM_AGE_SELECT_EN
  logic [ENT_NUM-1:0][ENT_SEL-1:0] age;

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENT_NUM; i++) begin
      if (dp_write && free_idx == ENT_SEL'(i))
        age[i] <= '0;
      else if (issue && !grant[i] && age[i] != '1)
        age[i] <= age[i] + ENT_SEL'(1);
    end
  end
`endif

  rs_custom_select #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL)) u_select (
    .ready     (ready),
`ifdef RS_CUSTOM_AGE_SELECT_EN
    .ages      (age),
`endif
    .grant     (grant),
    .grant_idx (sel_idx),
    .any_ready (any_ready)
  );

  assign ex_src1     = src1[sel_idx];
  assign ex_src2     = src2[sel_idx];
  assign ex_imm      = pay[sel_idx].imm;
  assign ex_rrftag   = pay[sel_idx].rrftag;
  assign ex_dstval   = pay[sel_idx].dstval;
  assign ex_src_a    = pay[sel_idx].src_a;
  assign ex_src_b    = pay[sel_idx].src_b;
  assign ex_funct7   = pay[sel_idx].funct7;
  assign ex_funct3   = pay[sel_idx].funct3;
  assign ex_passbits = pay[sel_idx].passbits;
  assign ex_spectag  = pay[sel_idx].spectag;
  assign ex_specbit  = pay[sel_idx].specbit;

endmodule
